wb_issue_arbiter: RTL and testbench

Write-back issue side that feeds the bypass buffer and register file. It collects results from NUM_UNIT execution units, each through its own small FIFO, and arbitrates among them. It drives one write-back (valid, index, data) per cycle, honouring the buffer's Full and the pipeline Stall. Slice results are issued as locked bursts with auto-incremented indices, matching the buffer's slice run/clear handling.

---
 rtl/wb_issue_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_wb_issue_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_issue_arbiter.sv
// Write-back issue arbiter: per-unit result FIFOs feeding one registered write-back port,
// with locked slice bursts. Define WB_FIXED_PRIO_EN for fixed-priority IDLE grants.
module wb_issue_arbiter #(
  parameter int unsigned NUM_UNIT   = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned IDX_W      = 8,
  parameter int unsigned LEN_W      = 4,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_UNIT-1:0]          I_Unit_Valid,
  input  logic [NUM_UNIT*IDX_W-1:0]    I_Unit_Index,
  input  logic [NUM_UNIT*LEN_W-1:0]    I_Unit_Len,
  input  logic [NUM_UNIT*DATA_W-1:0]   I_Unit_Data,
  output logic [NUM_UNIT-1:0]          O_Unit_Ready,
  input  logic                         I_Full,
  input  logic                         I_Stall,
  output logic                         O_WB_Valid,
  output logic [IDX_W-1:0]             O_WB_Index,
  output logic [DATA_W-1:0]            O_WB_Data,
  output logic                         O_Busy
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned UNIT_W = (NUM_UNIT > 1) ? $clog2(NUM_UNIT) : 1;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_t;

  entry_t             mem_q    [NUM_UNIT][FIFO_DEPTH];
  entry_t             entry_in [NUM_UNIT];
  entry_t             head     [NUM_UNIT];
  logic [PTR_W-1:0]   wr_ptr_q [NUM_UNIT];
  logic [PTR_W-1:0]   wr_ptr_d [NUM_UNIT];
  logic [PTR_W-1:0]   rd_ptr_q [NUM_UNIT];
  logic [PTR_W-1:0]   rd_ptr_d [NUM_UNIT];
  logic [CNT_W-1:0]   count_q  [NUM_UNIT];
  logic [CNT_W-1:0]   count_d  [NUM_UNIT];
  logic [NUM_UNIT-1:0] push, pop, nonempty, full;

  state_t             state_q, state_d;
  logic [UNIT_W-1:0]  rr_q, rr_d, lock_q, lock_d;
  logic [UNIT_W-1:0]  start, grant;
  logic               grant_valid;
  logic [IDX_W-1:0]   base_q, base_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d, k_q, k_d;
  logic               wb_valid_q, wb_valid_d;
  logic [IDX_W-1:0]   wb_index_q, wb_index_d;
  logic [DATA_W-1:0]  wb_data_q, wb_data_d;
  logic               busy_q, busy_d;
  logic               en;
  entry_t             gnt_head, lock_head;

  function automatic logic [UNIT_W-1:0] next_unit(input logic [UNIT_W-1:0] u);
    if (u == UNIT_W'(NUM_UNIT - 1)) return '0;
    return u + 1'b1;
  endfunction

  assign en           = ~I_Full & ~I_Stall;
  assign O_Unit_Ready = ~full;
  assign gnt_head     = head[grant];
  assign lock_head    = head[lock_q];

  // FIFO status and input unpacking; ready reflects the registered count only
  always_comb begin
    for (int u = 0; u < NUM_UNIT; u++) begin
      entry_in[u].idx  = I_Unit_Index[u*IDX_W +: IDX_W];
      entry_in[u].len  = I_Unit_Len[u*LEN_W +: LEN_W];
      entry_in[u].data = I_Unit_Data[u*DATA_W +: DATA_W];
      full[u]          = (count_q[u] == CNT_W'(FIFO_DEPTH));
      nonempty[u]      = (count_q[u] != '0);
      push[u]          = I_Unit_Valid[u] & ~full[u];
      head[u]          = mem_q[u][rd_ptr_q[u]];
    end
  end

  always_comb begin
    for (int u = 0; u < NUM_UNIT; u++) begin
      wr_ptr_d[u] = wr_ptr_q[u] + PTR_W'(push[u]);
      rd_ptr_d[u] = rd_ptr_q[u] + PTR_W'(pop[u]);
      count_d[u]  = count_q[u] + CNT_W'(push[u]) - CNT_W'(pop[u]);
    end
  end

`ifdef WB_FIXED_PRIO_EN
  assign start = '0;
`else
  assign start = rr_q;
`endif

  // First non-empty unit at or after the start pointer, wrapping
  always_comb begin
    int cand;
    grant_valid = 1'b0;
    grant       = '0;
    cand        = 0;
    for (int i = 0; i < NUM_UNIT; i++) begin
      cand = (int'(start) + i) % NUM_UNIT;
      if (!grant_valid && nonempty[UNIT_W'(cand)]) begin
        grant_valid = 1'b1;
        grant       = UNIT_W'(cand);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (en && grant_valid && gnt_head.len != '0) state_d = ST_BURST;
      ST_BURST: if (en && nonempty[lock_q] && cnt_q == LEN_W'(1)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Pop selection and write-back datapath
  always_comb begin
    pop        = '0;
    wb_valid_d = 1'b0;
    wb_index_d = wb_index_q;
    wb_data_d  = wb_data_q;
    rr_d       = rr_q;
    lock_d     = lock_q;
    base_d     = base_q;
    cnt_d      = cnt_q;
    k_d        = k_q;
    busy_d     = (|nonempty) | (state_q == ST_BURST);
    case (state_q)
      ST_IDLE: begin
        if (en && grant_valid) begin
          pop[grant] = 1'b1;
          wb_valid_d = 1'b1;
          wb_index_d = gnt_head.idx;
          wb_data_d  = gnt_head.data;
          if (gnt_head.len == '0) begin
            rr_d = next_unit(grant);
          end else begin
            lock_d = grant;
            base_d = gnt_head.idx;
            cnt_d  = gnt_head.len;
            k_d    = LEN_W'(1);
          end
        end
      end
      ST_BURST: begin
        if (en && nonempty[lock_q]) begin
          pop[lock_q] = 1'b1;
          wb_valid_d  = 1'b1;
          wb_index_d  = base_q + IDX_W'(k_q);
          wb_data_d   = lock_head.data;
          k_d         = k_q + LEN_W'(1);
          cnt_d       = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) rr_d = next_unit(lock_q);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int u = 0; u < NUM_UNIT; u++) begin
        wr_ptr_q[u] <= '0;
        rd_ptr_q[u] <= '0;
        count_q[u]  <= '0;
      end
      rr_q       <= '0;
      lock_q     <= '0;
      base_q     <= '0;
      cnt_q      <= '0;
      k_q        <= '0;
      wb_valid_q <= 1'b0;
      wb_index_q <= '0;
      wb_data_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      for (int u = 0; u < NUM_UNIT; u++) begin
        wr_ptr_q[u] <= wr_ptr_d[u];
        rd_ptr_q[u] <= rd_ptr_d[u];
        count_q[u]  <= count_d[u];
      end
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      base_q     <= base_d;
      cnt_q      <= cnt_d;
      k_q        <= k_d;
      wb_valid_q <= wb_valid_d;
      wb_index_q <= wb_index_d;
      wb_data_q  <= wb_data_d;
      busy_q     <= busy_d;
    end
  end

  // FIFO storage needs no reset; emptiness is tracked by the counts
  always_ff @(posedge clock) begin
    for (int u = 0; u < NUM_UNIT; u++) begin
      if (push[u]) mem_q[u][wr_ptr_q[u]] <= entry_in[u];
    end
  end

  assign O_WB_Valid = wb_valid_q;
  assign O_WB_Index = wb_index_q;
  assign O_WB_Data  = wb_data_q;
  assign O_Busy     = busy_q;

endmodule

// File: tb/tb_wb_issue_arbiter.sv
// Directed bench for wb_issue_arbiter: expected write-backs are queued when pushed and
// compared in order as the DUT issues them.
module tb_wb_issue_arbiter;
  localparam int unsigned NUM_UNIT = 2;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned IDX_W = 8;
  localparam int unsigned LEN_W = 4;
  localparam int unsigned DATA_W = 32;

  logic                        clock = 1'b0;
  logic                        reset;
  logic [NUM_UNIT-1:0]         I_Unit_Valid;
  logic [NUM_UNIT*IDX_W-1:0]   I_Unit_Index;
  logic [NUM_UNIT*LEN_W-1:0]   I_Unit_Len;
  logic [NUM_UNIT*DATA_W-1:0]  I_Unit_Data;
  logic [NUM_UNIT-1:0]         O_Unit_Ready;
  logic                        I_Full;
  logic                        I_Stall;
  logic                        O_WB_Valid;
  logic [IDX_W-1:0]            O_WB_Index;
  logic [DATA_W-1:0]           O_WB_Data;
  logic                        O_Busy;

  int n_checks = 0;
  int n_fail = 0;
  logic [IDX_W+DATA_W-1:0] sb[$];

  wb_issue_arbiter #(
    .NUM_UNIT(NUM_UNIT), .FIFO_DEPTH(FIFO_DEPTH), .IDX_W(IDX_W),
    .LEN_W(LEN_W), .DATA_W(DATA_W)
  ) dut (
    .clock(clock), .reset(reset),
    .I_Unit_Valid(I_Unit_Valid), .I_Unit_Index(I_Unit_Index),
    .I_Unit_Len(I_Unit_Len), .I_Unit_Data(I_Unit_Data),
    .O_Unit_Ready(O_Unit_Ready), .I_Full(I_Full), .I_Stall(I_Stall),
    .O_WB_Valid(O_WB_Valid), .O_WB_Index(O_WB_Index), .O_WB_Data(O_WB_Data),
    .O_Busy(O_Busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_unit(input int u, input logic v, input logic [IDX_W-1:0] idx,
                          input logic [LEN_W-1:0] len, input logic [DATA_W-1:0] data);
    I_Unit_Valid[u] = v;
    I_Unit_Index[u*IDX_W +: IDX_W] = idx;
    I_Unit_Len[u*LEN_W +: LEN_W] = len;
    I_Unit_Data[u*DATA_W +: DATA_W] = data;
  endtask

  task automatic push_exp(input logic [IDX_W-1:0] idx, input logic [DATA_W-1:0] data);
    sb.push_back({idx, data});
  endtask

  // Advance one clock, sample 1ns later, and score any issued write-back
  task automatic tick();
    logic [IDX_W+DATA_W-1:0] e;
    @(posedge clock);
    #1;
    if (O_WB_Valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", 64'(O_WB_Valid), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("wb_index", 64'(O_WB_Index), 64'(e[IDX_W+DATA_W-1:DATA_W]));
        chk("wb_data", 64'(O_WB_Data), 64'(e[DATA_W-1:0]));
      end
    end
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && sb.size() != 0; i++) tick();
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic clear_inputs();
    I_Unit_Valid = '0;
    I_Unit_Index = '0;
    I_Unit_Len   = '0;
    I_Unit_Data  = '0;
    I_Full       = 1'b0;
    I_Stall      = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    sb.delete();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic rdy;
    logic accepted;
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    chk("rst_valid", 64'(O_WB_Valid), 64'd0);
    chk("rst_index", 64'(O_WB_Index), 64'd0);
    chk("rst_data", 64'(O_WB_Data), 64'd0);
    chk("rst_ready", 64'(O_Unit_Ready), 64'd3);
    chk("rst_busy", 64'(O_Busy), 64'd0);
    reset = 1'b0;
    tick();

    // Scalar single issue, latency and busy drop
    set_unit(0, 1'b1, 8'h05, 4'd0, 32'hDEADBEEF);
    push_exp(8'h05, 32'hDEADBEEF);
    tick();
    set_unit(0, 1'b0, 8'h00, 4'd0, 32'h0);
    chk("t1_no_valid_yet", 64'(O_WB_Valid), 64'd0);
    tick();
    chk("t1_valid", 64'(O_WB_Valid), 64'd1);
    chk("t1_busy_high", 64'(O_Busy), 64'd1);
    tick();
    chk("t1_valid_drop", 64'(O_WB_Valid), 64'd0);
    chk("t1_busy_drop", 64'(O_Busy), 64'd0);
    chk("t1_index_hold", 64'(O_WB_Index), 64'h05);
    chk("t1_data_hold", 64'(O_WB_Data), 64'hDEADBEEF);

    // Two units, two scalars each
    do_reset();
`ifdef WB_FIXED_PRIO_EN
    push_exp(8'h10, 32'h100); push_exp(8'h11, 32'h110);
    push_exp(8'h20, 32'h200); push_exp(8'h21, 32'h210);
`else
    push_exp(8'h10, 32'h100); push_exp(8'h20, 32'h200);
    push_exp(8'h11, 32'h110); push_exp(8'h21, 32'h210);
`endif
    set_unit(0, 1'b1, 8'h10, 4'd0, 32'h100);
    set_unit(1, 1'b1, 8'h20, 4'd0, 32'h200);
    tick();
    set_unit(0, 1'b1, 8'h11, 4'd0, 32'h110);
    set_unit(1, 1'b1, 8'h21, 4'd0, 32'h210);
    tick();
    chk("t2_valid0", 64'(O_WB_Valid), 64'd1);
    clear_inputs();
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("t2_valid_consec", 64'(O_WB_Valid), 64'd1);
    end
    tick();
    chk("t2_idle_after", 64'(O_WB_Valid), 64'd0);
    chk("t2_sb_empty", 64'(sb.size()), 64'd0);

    // Locked burst with index wrap, competing scalar waits
    do_reset();
    push_exp(8'hFE, 32'd1); push_exp(8'hFF, 32'd2);
    push_exp(8'h00, 32'd3); push_exp(8'h01, 32'd4);
    push_exp(8'h30, 32'h3030);
    set_unit(0, 1'b1, 8'hFE, 4'd3, 32'd1);
    set_unit(1, 1'b1, 8'h30, 4'd0, 32'h3030);
    tick();
    set_unit(1, 1'b0, 8'h00, 4'd0, 32'h0);
    for (int d = 2; d <= 4; d++) begin
      set_unit(0, 1'b1, 8'hAA, 4'd7, 32'(d));
      tick();
      chk("t3_burst_valid", 64'(O_WB_Valid), 64'd1);
    end
    set_unit(0, 1'b0, 8'h00, 4'd0, 32'h0);
    tick();
    chk("t3_last_valid", 64'(O_WB_Valid), 64'd1);
    chk("t3_busy_in_burst", 64'(O_Busy), 64'd1);
    tick();
    chk("t3_scalar_after", 64'(O_WB_Valid), 64'd1);
    drain(4);

    // Backpressure from Full, then from Stall
    for (int m = 0; m < 2; m++) begin
      do_reset();
      if (m == 0) I_Full = 1'b1;
      else        I_Stall = 1'b1;
      push_exp(8'h40, 32'h400); push_exp(8'h41, 32'h410);
      set_unit(0, 1'b1, 8'h40, 4'd0, 32'h400);
      tick();
      chk("t4_hold", 64'(O_WB_Valid), 64'd0);
      set_unit(0, 1'b1, 8'h41, 4'd0, 32'h410);
      tick();
      chk("t4_hold", 64'(O_WB_Valid), 64'd0);
      set_unit(0, 1'b0, 8'h00, 4'd0, 32'h0);
      tick();
      chk("t4_hold", 64'(O_WB_Valid), 64'd0);
      I_Full  = 1'b0;
      I_Stall = 1'b0;
      tick();
      chk("t4_release1", 64'(O_WB_Valid), 64'd1);
      tick();
      chk("t4_release2", 64'(O_WB_Valid), 64'd1);
      tick();
      chk("t4_done", 64'(O_WB_Valid), 64'd0);
      chk("t4_sb_empty", 64'(sb.size()), 64'd0);
    end

    // FIFO full: fifth push held until an entry drains
    do_reset();
    I_Stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t5_ready_before_push", 64'(O_Unit_Ready[1]), 64'd1);
      set_unit(1, 1'b1, 8'h50 + 8'(i), 4'd0, 32'h500 + 32'(i));
      push_exp(8'h50 + 8'(i), 32'h500 + 32'(i));
      tick();
    end
    chk("t5_ready_full", 64'(O_Unit_Ready[1]), 64'd0);
    set_unit(1, 1'b1, 8'h54, 4'd0, 32'h504);
    push_exp(8'h54, 32'h504);
    tick();
    tick();
    chk("t5_still_full", 64'(O_Unit_Ready[1]), 64'd0);
    chk("t5_no_issue", 64'(O_WB_Valid), 64'd0);
    I_Stall = 1'b0;
    accepted = 1'b0;
    for (int i = 0; i < 8 && !accepted; i++) begin
      rdy = O_Unit_Ready[1];
      tick();
      if (i == 0) chk("t5_ready_returns", 64'(O_Unit_Ready[1]), 64'd1);
      if (rdy) begin
        accepted = 1'b1;
        set_unit(1, 1'b0, 8'h00, 4'd0, 32'h0);
      end
    end
    chk("t5_fifth_accepted", 64'(accepted), 64'd1);
    drain(20);

    // Reset in the middle of a burst
    do_reset();
    push_exp(8'h10, 32'd1); push_exp(8'h11, 32'd2);
    set_unit(0, 1'b1, 8'h10, 4'd3, 32'd1);
    tick();
    set_unit(0, 1'b1, 8'hAA, 4'd0, 32'd2);
    tick();
    set_unit(0, 1'b1, 8'hAA, 4'd0, 32'd3);
    tick();
    chk("t6_two_issued", 64'(sb.size()), 64'd0);
    set_unit(0, 1'b0, 8'h00, 4'd0, 32'h0);
    reset = 1'b1;
    tick();
    chk("t6_rst_valid", 64'(O_WB_Valid), 64'd0);
    chk("t6_rst_index", 64'(O_WB_Index), 64'd0);
    chk("t6_rst_data", 64'(O_WB_Data), 64'd0);
    chk("t6_rst_ready", 64'(O_Unit_Ready), 64'd3);
    chk("t6_rst_busy", 64'(O_Busy), 64'd0);
    reset = 1'b0;
    tick();
    chk("t6_busy_after", 64'(O_Busy), 64'd0);
    push_exp(8'h77, 32'h7777);
    set_unit(0, 1'b1, 8'h77, 4'd0, 32'h7777);
    tick();
    set_unit(0, 1'b0, 8'h00, 4'd0, 32'h0);
    tick();
    chk("t6_scalar_valid", 64'(O_WB_Valid), 64'd1);
    tick();
    chk("t6_no_stale_burst", 64'(O_WB_Valid), 64'd0);
    drain(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
